// File: rtl/alu_s_pkg.sv
// alu_s_pkg: opcodes, error bit positions and sequencer FSM states shared with alu_s users
package alu_s_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR = 3'b110;
  localparam logic [2:0] OP_INVALID = 3'b111;
  localparam int ERR_INVALID = 0;
  localparam int ERR_DIVZERO = 1;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
endpackage

// File: rtl/alu_s_sequencer_if.sv
// alu_s_sequencer_if: command and response handshake ports of the alu_s sequencer
interface alu_s_sequencer_if #(parameter int SIZE = 32);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_control;
  logic [SIZE-1:0] cmd_num1;
  logic [SIZE-1:0] cmd_num2;
  logic rsp_valid;
  logic rsp_ready;
  logic [2*SIZE-1:0] rsp_output1;
  logic [2*SIZE-1:0] rsp_output2;
  logic [1:0] rsp_error;
  modport master (
    output cmd_valid, cmd_control, cmd_num1, cmd_num2, rsp_ready,
    input cmd_ready, rsp_valid, rsp_output1, rsp_output2, rsp_error
  );
  modport slave (
    input cmd_valid, cmd_control, cmd_num1, cmd_num2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_output1, rsp_output2, rsp_error
  );
endinterface

// File: rtl/alu_s_sequencer.sv
// alu_s_sequencer: issues one command to alu_s, waits SETTLE_CYCLES, returns the captured result
module alu_s_sequencer
  import alu_s_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_s_sequencer_if.slave    bus,
  output logic [2:0]          alu_control,
  output logic [SIZE-1:0]     alu_num1,
  output logic [SIZE-1:0]     alu_num2,
  input  logic [2*SIZE-1:0]   alu_output1,
  input  logic [2*SIZE-1:0]   alu_output2,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic accept;
  logic rsp_hs;
  logic [1:0] err;
  assign bus.cmd_ready = state == IDLE || (state == RESP && bus.rsp_ready);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;
  assign busy = state != IDLE;
  // errors are judged on the registered command actually presented to alu_s
  always_comb begin
    err = '0;
    err[ERR_INVALID] = alu_control == OP_INVALID;
    err[ERR_DIVZERO] = alu_control == OP_DIV && alu_num2 == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      alu_control <= '0;
      alu_num1 <= '0;
      alu_num2 <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_output1 <= '0;
      bus.rsp_output2 <= '0;
      bus.rsp_error <= '0;
      op_count <= '0;
    end else begin
      if (rsp_hs) begin
        bus.rsp_valid <= 1'b0;
        op_count <= op_count + 1'b1;
      end
      if (accept) begin
        alu_control <= bus.cmd_control;
        alu_num1 <= bus.cmd_num1;
        alu_num2 <= bus.cmd_num2;
        cnt <= CW'(SETTLE_CYCLES - 1);
        state <= SETTLE;
      end else if (state == RESP && rsp_hs) begin
        state <= IDLE;
      end
      if (state == SETTLE) begin
        if (cnt == '0) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_output1 <= |err ? '0 : alu_output1;
          bus.rsp_output2 <= |err ? '0 : alu_output2;
          bus.rsp_error <= err;
          state <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_s_sequencer.sv
// tb_alu_s_sequencer: transaction-level model check of the sequencer with a behavioural alu_s beside it
module tb_alu_s_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  alu_s_sequencer_if #(.SIZE(8)) bus ();
  alu_s_sequencer_if #(.SIZE(8)) bus4 ();
  logic [2:0] alu_control, alu_control4;
  logic [7:0] alu_num1, alu_num2, alu_num14, alu_num24;
  logic [15:0] alu_output1, alu_output2, alu_output14, alu_output24;
  logic busy, busy4;
  logic [3:0] op_count;
  logic [15:0] op_count4;

  alu_s_sequencer #(.SIZE(8), .SETTLE_CYCLES(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .alu_control(alu_control), .alu_num1(alu_num1),
    .alu_num2(alu_num2), .alu_output1(alu_output1), .alu_output2(alu_output2),
    .busy(busy), .op_count(op_count)
  );
  alu_s_sequencer #(.SIZE(8), .SETTLE_CYCLES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4), .alu_control(alu_control4), .alu_num1(alu_num14),
    .alu_num2(alu_num24), .alu_output1(alu_output14), .alu_output2(alu_output24),
    .busy(busy4), .op_count(op_count4)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // signed alu_s behaviour: {output1, output2}, both sign-extended to 16 bits
  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x, y, o1, o2;
    x = 16'(signed'(a));
    y = 16'(signed'(b));
    o1 = '0;
    o2 = '0;
    case (c)
      3'd0: o1 = x + y;
      3'd1: o1 = x - y;
      3'd2: o1 = x * y;
      3'd3: if (y != 0) begin o1 = x / y; o2 = x % y; end
      3'd4: o1 = ~x;
      3'd5: o1 = x & y;
      3'd6: o1 = x | y;
      default: o1 = '0;
    endcase
    return {o1, o2};
  endfunction

  // the stand-in alu_s puts junk on the bus for error cases so the sequencer's zeroing is visible
  function automatic logic [31:0] alu_stub(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    if (c == 3'd7 || (c == 3'd3 && b == 0)) return 32'hDEAD_BEEF;
    return alu_fn(c, a, b);
  endfunction

  always_comb {alu_output1, alu_output2} = alu_stub(alu_control, alu_num1, alu_num2);
  always_comb {alu_output14, alu_output24} = alu_stub(alu_control4, alu_num14, alu_num24);

  function automatic logic [33:0] expect_rsp(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [1:0] e;
    e = {c == 3'd3 && b == 0, c == 3'd7};
    return |e ? {e, 32'h0} : {2'b00, alu_fn(c, a, b)};
  endfunction

  // transaction model: one outstanding op, response due SETTLE cycles after its accept
  int cyc = 0;
  int rdy = 0;
  logic have = 1'b0;
  logic [2:0] lc = '0;
  logic [7:0] la = '0, lb = '0;
  logic [3:0] m_cnt = '0;
  logic e_rv = 1'b0;
  logic e_cr = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      have = 1'b0; lc = '0; la = '0; lb = '0; m_cnt = '0;
    end else begin
      if (e_rv && bus.rsp_ready) begin
        have = 1'b0;
        m_cnt = m_cnt + 4'd1;
      end
      if (bus.cmd_valid && e_cr) begin
        have = 1'b1;
        lc = bus.cmd_control; la = bus.cmd_num1; lb = bus.cmd_num2;
        rdy = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] r;
    e_rv = have && cyc >= rdy;
    e_cr = !have || (e_rv && bus.rsp_ready);
    if (!rst) begin
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(e_cr));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
      chk("busy", 64'(busy), 64'(have));
      chk("op_count", 64'(op_count), 64'(m_cnt));
      chk("alu_in", {40'h0, alu_control, 5'h0, alu_num1, alu_num2}, {40'h0, lc, 5'h0, la, lb});
      if (e_rv) begin
        r = expect_rsp(lc, la, lb);
        chk("rsp_error", 64'(bus.rsp_error), 64'(r[33:32]));
        chk("rsp_output1", 64'(bus.rsp_output1), 64'(r[31:16]));
        chk("rsp_output2", 64'(bus.rsp_output2), 64'(r[15:0]));
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    logic ok;
    bus.cmd_valid = 1'b1; bus.cmd_control = c; bus.cmd_num1 = a; bus.cmd_num2 = b;
    do begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 20);
    bus.cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bus.cmd_valid = 0; bus.cmd_control = 0; bus.cmd_num1 = 0; bus.cmd_num2 = 0; bus.rsp_ready = 0;
    bus4.cmd_valid = 0; bus4.cmd_control = 0; bus4.cmd_num1 = 0; bus4.cmd_num2 = 0; bus4.rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    // add 5 + -3
    send(3'd0, 8'd5, 8'hFD);
    wait_rsp(lat);
    chk("t1_latency", 64'(lat), 64'd1);
    chk("t1_output1", 64'(bus.rsp_output1), 64'd2);
    chk("t1_error", 64'(bus.rsp_error), 64'd0);
    consume();
    @(negedge clk);
    chk("t1_op_count", 64'(op_count), 64'd1);
    @(posedge clk); #1;
    // div 7 / 2
    send(3'd3, 8'd7, 8'd2);
    wait_rsp(lat);
    chk("t2_output1", 64'(bus.rsp_output1), 64'd3);
    chk("t2_output2", 64'(bus.rsp_output2), 64'd1);
    chk("t2_error", 64'(bus.rsp_error), 64'd0);
    consume();
    // div by zero
    send(3'd3, 8'd9, 8'd0);
    wait_rsp(lat);
    chk("t3_latency", 64'(lat), 64'd1);
    chk("t3_error", 64'(bus.rsp_error), 64'd2);
    chk("t3_outputs", {32'h0, bus.rsp_output1, bus.rsp_output2}, 64'd0);
    consume();
    // invalid opcode, response stalled with a command waiting
    send(3'd7, 8'd1, 8'd2);
    wait_rsp(lat);
    chk("t4_error", 64'(bus.rsp_error), 64'd1);
    chk("t4_output1", 64'(bus.rsp_output1), 64'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_control = 3'd0; bus.cmd_num1 = 8'd10; bus.cmd_num2 = 8'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", 64'(bus.cmd_ready), 64'd0);
      chk("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t4_hold_error", 64'(bus.rsp_error), 64'd1);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_same_cycle", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("t4_next_latency", 64'(lat), 64'd1);
    chk("t4_next_output1", 64'(bus.rsp_output1), 64'd30);
    consume();
    // 16 back-to-back ops on a 4-bit counter after a fresh reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(3'(i % 8), 8'(i * 13 - 50), 8'(i - 3));
    wait_rsp(lat);
    @(negedge clk);
    chk("t6_op_count_wrap", 64'(op_count), 64'd0);
    chk("t6_rsp_dropped", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b0;
    // SETTLE_CYCLES=4 instance: full latency, then reset in mid-settle
    @(posedge clk); #1 rst4 = 1'b0;
    bus4.cmd_valid = 1'b1; bus4.cmd_control = 3'd2; bus4.cmd_num1 = 8'd6; bus4.cmd_num2 = 8'hFE;
    @(posedge clk); #1 bus4.cmd_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus4.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("t5_latency", 64'(lat), 64'd4);
    chk("t5_output1", 64'(bus4.rsp_output1), 64'hFFF4);
    @(posedge clk); #1 bus4.rsp_ready = 1'b1;
    @(posedge clk); #1 bus4.rsp_ready = 1'b0;
    @(negedge clk);
    chk("t5_op_count", 64'(op_count4), 64'd1);
    @(posedge clk); #1;
    bus4.cmd_valid = 1'b1; bus4.cmd_control = 3'd6; bus4.cmd_num1 = 8'd5; bus4.cmd_num2 = 8'd3;
    @(posedge clk); #1 bus4.cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst4 = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy4), 64'd0);
    chk("t5_rst_alu", {40'h0, alu_control4, 5'h0, alu_num14, alu_num24}, 64'd0);
    chk("t5_rst_op_count", 64'(op_count4), 64'd0);
    chk("t5_rst_rsp", {31'h0, bus4.rsp_valid, bus4.rsp_output1, bus4.rsp_output2}, 64'd0);
    @(posedge clk); @(posedge clk); #1 rst4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 64'(bus4.rsp_valid), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
